// File: rtl/cr_prefix_rec_mac.sv
// Per-lane multiply-accumulate with saturating accumulators and shift/ReLU/saturate activation.
// Pipeline: input regs -> S1 product -> S2 accumulate -> S3 activation; rec_us_hold freezes every register.
module cr_prefix_rec_mac #(
  parameter int N_NEURONS = 128,
  parameter int NW        = 8,
  parameter int ACC_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_NEURONS*NW-1:0] rec_di_coeff,
  input  logic [N_NEURONS*NW-1:0] rec_di_neuron,
  input  logic                    rec_di_neuron_sign,
  input  logic                    rec_us_hold,
  input  logic                    rec_us_mac,
  input  logic                    rec_us_acc_clr,
  input  logic                    rec_us_act,
  input  logic                    rec_us_relu,
  input  logic [3:0]              rec_us_shift,
  output logic [N_NEURONS*NW-1:0] rec_act_result,
  output logic                    rec_act_valid,
  output logic                    rec_mac_ovf
);
  localparam int PW = 2 * NW + 2;

  // Operands are registered ahead of the multiplier so accumulators move two edges after sampling.
  logic [N_NEURONS*NW-1:0] in_coeff, in_neuron;
  logic                    in_sign, in_mac, in_clr, in_act, in_relu;
  logic [3:0]              in_shift;

  logic [PW-1:0]           s1_prod [N_NEURONS];
  logic                    s1_mac, s1_clr, s1_act, s1_relu;
  logic [3:0]              s1_shift;

  logic [ACC_W-1:0]        acc [N_NEURONS];
  logic                    s2_act, s2_relu;
  logic [3:0]              s2_shift;

  logic [PW-1:0]           prod_d [N_NEURONS];
  logic [ACC_W:0]          sum    [N_NEURONS];
  logic [ACC_W-1:0]        acc_d  [N_NEURONS];
  logic [ACC_W-1:0]        shf    [N_NEURONS];
  logic [ACC_W-1:0]        rl     [N_NEURONS];
  logic [N_NEURONS-1:0]    sat_lane;
  logic [N_NEURONS*NW-1:0] act_d;

  always_comb begin
    sat_lane = '0;
    act_d    = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      prod_d[i] = {{(PW-NW){in_coeff[i*NW+NW-1]}}, in_coeff[i*NW +: NW]} *
                  {{(PW-NW){in_sign & in_neuron[i*NW+NW-1]}}, in_neuron[i*NW +: NW]};

      sum[i] = {acc[i][ACC_W-1], acc[i]} + {{(ACC_W+1-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
      acc_d[i] = acc[i];
      if (s1_clr) begin
        acc_d[i] = s1_mac ? {{(ACC_W-PW){s1_prod[i][PW-1]}}, s1_prod[i]} : '0;
      end else if (s1_mac) begin
        if (sum[i][ACC_W] != sum[i][ACC_W-1]) begin
          sat_lane[i] = 1'b1;
          acc_d[i] = sum[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          acc_d[i] = sum[i][ACC_W-1:0];
        end
      end

      // S3 reads the registered accumulators, which already hold the update from the act's own cycle.
      shf[i] = $signed(acc[i]) >>> s2_shift;
      rl[i]  = (s2_relu && shf[i][ACC_W-1]) ? '0 : shf[i];
      if ((&rl[i][ACC_W-1:NW-1]) || !(|rl[i][ACC_W-1:NW-1])) begin
        act_d[i*NW +: NW] = rl[i][NW-1:0];
      end else begin
        act_d[i*NW +: NW] = rl[i][ACC_W-1] ? {1'b1, {(NW-1){1'b0}}} : {1'b0, {(NW-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_mac         <= 1'b0;
      in_clr         <= 1'b0;
      in_act         <= 1'b0;
      in_relu        <= 1'b0;
      in_sign        <= 1'b0;
      in_shift       <= '0;
      s1_mac         <= 1'b0;
      s1_clr         <= 1'b0;
      s1_act         <= 1'b0;
      s1_relu        <= 1'b0;
      s1_shift       <= '0;
      acc            <= '{default: '0};
      s2_act         <= 1'b0;
      s2_relu        <= 1'b0;
      s2_shift       <= '0;
      rec_mac_ovf    <= 1'b0;
      rec_act_result <= '0;
      rec_act_valid  <= 1'b0;
    end else if (!rec_us_hold) begin
      in_coeff       <= rec_di_coeff;
      in_neuron      <= rec_di_neuron;
      in_sign        <= rec_di_neuron_sign;
      in_mac         <= rec_us_mac;
      in_clr         <= rec_us_acc_clr;
      in_act         <= rec_us_act;
      in_relu        <= rec_us_relu;
      in_shift       <= rec_us_shift;

      s1_prod        <= prod_d;
      s1_mac         <= in_mac;
      s1_clr         <= in_clr;
      s1_act         <= in_act;
      s1_relu        <= in_relu;
      s1_shift       <= in_shift;

      acc            <= acc_d;
      rec_mac_ovf    <= s1_clr ? 1'b0 : (rec_mac_ovf | (|sat_lane));
      s2_act         <= s1_act;
      s2_relu        <= s1_relu;
      s2_shift       <= s1_shift;

      if (s2_act) begin
        rec_act_result <= act_d;
      end
      rec_act_valid  <= s2_act;
    end
  end
endmodule

// File: tb/tb_cr_prefix_rec_mac.sv
// Bench for cr_prefix_rec_mac: directed table, latency/hold/reset sequences and random traffic
// checked every cycle against an arithmetic model of the accumulators.
module tb_cr_prefix_rec_mac;
  localparam int N     = 128;
  localparam int NW    = 8;
  localparam int ACC_W = 20;
  localparam int RW    = N * NW;
  localparam int AMAX  = (1 << (ACC_W - 1)) - 1;
  localparam int AMIN  = -(1 << (ACC_W - 1));

  logic          clk;
  logic          rst;
  logic [RW-1:0] rec_di_coeff, rec_di_neuron;
  logic          rec_di_neuron_sign, rec_us_hold, rec_us_mac, rec_us_acc_clr;
  logic          rec_us_act, rec_us_relu;
  logic [3:0]    rec_us_shift;
  logic [RW-1:0] rec_act_result;
  logic          rec_act_valid, rec_mac_ovf;

  cr_prefix_rec_mac #(.N_NEURONS(N), .NW(NW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .rec_di_coeff(rec_di_coeff), .rec_di_neuron(rec_di_neuron),
    .rec_di_neuron_sign(rec_di_neuron_sign), .rec_us_hold(rec_us_hold),
    .rec_us_mac(rec_us_mac), .rec_us_acc_clr(rec_us_acc_clr),
    .rec_us_act(rec_us_act), .rec_us_relu(rec_us_relu), .rec_us_shift(rec_us_shift),
    .rec_act_result(rec_act_result), .rec_act_valid(rec_act_valid), .rec_mac_ovf(rec_mac_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, hold, clr, mac, act, relu, sign;
    logic [3:0] shift;
    logic [RW-1:0] coeff, neuron;
  } cmd_t;

  typedef struct {
    logic [7:0] c, n;
    logic sign, relu;
    logic [3:0] sh;
    logic [7:0] exp;
  } vec_t;

  typedef struct packed {
    logic act;
    logic [RW-1:0] res;
  } act_e;

  int total = 0;
  int bad   = 0;

  // Reference state: plain integer accumulators plus output-visibility delays.
  int            macc [N];
  bit            movf;
  act_e          act_q [$];
  bit            ovf_q [$];
  logic          exp_valid, exp_ovf;
  logic [RW-1:0] exp_res;

  function automatic cmd_t mk(input logic clr, mac, act, relu, sign,
                              input logic [3:0] sh, input logic [7:0] c, n);
    cmd_t r;
    r = '0;
    r.clr = clr; r.mac = mac; r.act = act; r.relu = relu; r.sign = sign; r.shift = sh;
    r.coeff = {N{c}};
    r.neuron = {N{n}};
    return r;
  endfunction

  function automatic logic [RW-1:0] act_vec(input logic relu, input logic [3:0] sh);
    logic [RW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      v = macc[i] >>> sh;
      if (relu && v < 0) v = 0;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[i*NW +: NW] = 8'(v);
    end
    return r;
  endfunction

  task automatic model_reset();
    act_e z;
    z = '0;
    for (int i = 0; i < N; i++) macc[i] = 0;
    movf = 0;
    act_q = {};
    ovf_q = {};
    repeat (3) act_q.push_back(z);
    repeat (2) ovf_q.push_back(1'b0);
    exp_valid = 0; exp_ovf = 0; exp_res = '0;
  endtask

  task automatic model_step(input cmd_t c);
    act_e e;
    int cv, nv, s;
    logic [7:0] nb;
    if (c.rst) begin
      model_reset();
    end else if (!c.hold) begin
      if (c.clr) movf = 0;
      for (int i = 0; i < N; i++) begin
        cv = int'($signed(c.coeff[i*NW +: NW]));
        nb = c.neuron[i*NW +: NW];
        if (c.sign) nv = int'($signed(nb));
        else nv = int'(nb);
        if (c.clr) begin
          macc[i] = c.mac ? cv * nv : 0;
        end else if (c.mac) begin
          s = macc[i] + cv * nv;
          if (s > AMAX) begin s = AMAX; movf = 1; end
          if (s < AMIN) begin s = AMIN; movf = 1; end
          macc[i] = s;
        end
      end
      e.act = c.act;
      e.res = c.act ? act_vec(c.relu, c.shift) : '0;
      act_q.push_back(e);
      e = act_q.pop_front();
      exp_valid = e.act;
      if (e.act) exp_res = e.res;
      ovf_q.push_back(movf);
      exp_ovf = ovf_q.pop_front();
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    int j;
    total++;
    if (got !== exp) begin
      bad++;
      j = 0;
      while (j < N - 1 && got[j*NW +: NW] === exp[j*NW +: NW]) j++;
      $display("FAIL %s: lane %0d got %h expected %h (t=%0t)", nm, j,
               got[j*NW +: NW], exp[j*NW +: NW], $time);
    end
  endtask

  task automatic tick(input cmd_t c);
    rst = c.rst; rec_us_hold = c.hold; rec_us_acc_clr = c.clr; rec_us_mac = c.mac;
    rec_us_act = c.act; rec_us_relu = c.relu; rec_di_neuron_sign = c.sign;
    rec_us_shift = c.shift; rec_di_coeff = c.coeff; rec_di_neuron = c.neuron;
    @(posedge clk);
    #1;
    model_step(c);
    chk_bit("valid", rec_act_valid, exp_valid);
    chk_vec("result", rec_act_result, exp_res);
    chk_bit("ovf", rec_mac_ovf, exp_ovf);
  endtask

  task automatic wait_valid(input int bound, output int lat);
    cmd_t c;
    c = '0;
    lat = 0;
    for (int k = 1; k <= bound; k++) begin
      tick(c);
      if (rec_act_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t tbl [8];

  initial begin
    cmd_t c, idle, hold;
    int lat, l2;
    logic [7:0] got_q [$];
    logic [RW-1:0] zero_v;

    tbl[0] = '{c: 8'd3,   n: 8'd5,   sign: 1'b0, relu: 1'b0, sh: 4'd0, exp: 8'd15};
    tbl[1] = '{c: 8'hFE,  n: 8'hFF,  sign: 1'b1, relu: 1'b0, sh: 4'd1, exp: 8'd1};
    tbl[2] = '{c: 8'hFE,  n: 8'hFF,  sign: 1'b0, relu: 1'b0, sh: 4'd1, exp: 8'h80};
    tbl[3] = '{c: 8'hFE,  n: 8'hFF,  sign: 1'b0, relu: 1'b1, sh: 4'd0, exp: 8'h00};
    tbl[4] = '{c: 8'd127, n: 8'd255, sign: 1'b0, relu: 1'b0, sh: 4'd0, exp: 8'd127};
    tbl[5] = '{c: 8'h80,  n: 8'hFF,  sign: 1'b1, relu: 1'b0, sh: 4'd1, exp: 8'd64};
    tbl[6] = '{c: 8'h80,  n: 8'h80,  sign: 1'b0, relu: 1'b0, sh: 4'd8, exp: 8'hC0};
    tbl[7] = '{c: 8'd5,   n: 8'h80,  sign: 1'b1, relu: 1'b0, sh: 4'd3, exp: 8'hB0};

    idle = '0;
    hold = '0; hold.hold = 1'b1;
    zero_v = '0;
    model_reset();

    c = '0; c.rst = 1'b1;
    tick(c);
    tick(c);
    chk_vec("reset_result", rec_act_result, zero_v);
    chk_bit("reset_valid", rec_act_valid, 1'b0);

    // Directed table: single clr+mac+act, fixed latency of three edges.
    for (int k = 0; k < 8; k++) begin
      tick(mk(1, 1, 1, tbl[k].relu, tbl[k].sign, tbl[k].sh, tbl[k].c, tbl[k].n));
      wait_valid(8, lat);
      chk_int($sformatf("tbl%0d_lat", k), lat, 3);
      chk_vec($sformatf("tbl%0d_val", k), rec_act_result, {N{tbl[k].exp}});
    end

    // Accumulate to 129540, then drive into saturation.
    tick(mk(1, 1, 0, 0, 0, 4'd0, 8'd127, 8'd255));
    repeat (3) tick(mk(0, 1, 0, 0, 0, 4'd0, 8'd127, 8'd255));
    tick(mk(0, 0, 1, 0, 0, 4'd15, 8'd0, 8'd0));
    wait_valid(8, lat);
    chk_vec("acc129540_sh15", rec_act_result, {N{8'd3}});
    chk_bit("ovf_before_sat", rec_mac_ovf, 1'b0);
    repeat (20) tick(mk(0, 1, 0, 0, 0, 4'd0, 8'd127, 8'd255));
    tick(idle); tick(idle);
    chk_bit("ovf_after_sat", rec_mac_ovf, 1'b1);
    tick(mk(0, 0, 1, 0, 0, 4'd15, 8'd0, 8'd0));
    wait_valid(8, lat);
    chk_vec("sat_acc_sh15", rec_act_result, {N{8'd15}});
    tick(mk(1, 0, 0, 0, 0, 4'd0, 8'd0, 8'd0));
    tick(idle); tick(idle);
    chk_bit("ovf_cleared", rec_mac_ovf, 1'b0);

    // acc = -4096, three back-to-back activations.
    tick(mk(1, 1, 0, 0, 0, 4'd0, 8'h80, 8'h20));
    tick(mk(0, 0, 1, 0, 0, 4'd4, 8'd0, 8'd0));
    tick(mk(0, 0, 1, 1, 0, 4'd4, 8'd0, 8'd0));
    tick(mk(0, 0, 1, 0, 0, 4'd12, 8'd0, 8'd0));
    for (int k = 0; k < 6; k++) begin
      tick(idle);
      if (rec_act_valid) got_q.push_back(rec_act_result[7:0]);
    end
    chk_int("b2b_pulses", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk_int("neg_sh4", int'(got_q[0]), 8'h80);
      chk_int("neg_relu", int'(got_q[1]), 8'h00);
      chk_int("neg_sh12", int'(got_q[2]), 8'hFF);
    end

    // mac+act then three held cycles: pulse six edges after issue, including the mac.
    tick(mk(1, 1, 0, 0, 0, 4'd0, 8'd3, 8'd5));
    tick(mk(0, 1, 1, 0, 0, 4'd0, 8'd1, 8'd10));
    repeat (3) tick(hold);
    wait_valid(10, l2);
    chk_int("hold_lat", (l2 == 0) ? 0 : 3 + l2, 6);
    chk_vec("hold_val", rec_act_result, {N{8'd25}});

    // Hold while the pulse is high stretches it until the next unheld edge.
    tick(mk(0, 0, 1, 0, 0, 4'd0, 8'd0, 8'd0));
    wait_valid(8, lat);
    tick(hold);
    chk_bit("valid_held1", rec_act_valid, 1'b1);
    tick(hold);
    chk_bit("valid_held2", rec_act_valid, 1'b1);
    tick(idle);
    chk_bit("valid_released", rec_act_valid, 1'b0);

    // Reset one cycle after act issue discards it.
    tick(mk(0, 1, 1, 0, 0, 4'd0, 8'd7, 8'd7));
    c = '0; c.rst = 1'b1;
    tick(c);
    for (int k = 0; k < 5; k++) begin
      tick(idle);
      chk_bit("rst_no_pulse", rec_act_valid, 1'b0);
    end
    chk_vec("rst_result", rec_act_result, zero_v);
    chk_bit("rst_ovf", rec_mac_ovf, 1'b0);
    tick(mk(0, 0, 1, 0, 0, 4'd0, 8'd0, 8'd0));
    wait_valid(8, lat);
    chk_int("post_rst_lat", lat, 3);
    chk_vec("post_rst_act", rec_act_result, zero_v);

    // Random traffic against the model.
    for (int t = 0; t < 400; t++) begin
      c = '0;
      c.rst   = ($urandom_range(0, 99) == 0);
      c.hold  = ($urandom_range(0, 9) == 0);
      c.clr   = ($urandom_range(0, 9) == 0);
      c.mac   = ($urandom_range(0, 9) < 6);
      c.act   = ($urandom_range(0, 9) < 4);
      c.relu  = 1'($urandom_range(0, 1));
      c.sign  = 1'($urandom_range(0, 1));
      c.shift = 4'($urandom_range(0, 15));
      for (int j = 0; j < N; j++) begin
        c.coeff[j*NW +: NW]  = 8'($urandom);
        c.neuron[j*NW +: NW] = 8'($urandom);
      end
      tick(c);
    end
    repeat (4) tick(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cr_prefix_rec_mac.md
CR_PREFIX_REC_MAC -- requirements
Module: cr_prefix_rec_mac

Interface
REQ-001 Parameter N_NEURONS, default 128, number of neuron lanes.
REQ-002 Parameter NW, default 8, neuron/coefficient width (PREFIX_NEURON_WIDTH).
REQ-003 Parameter ACC_W, default 20, signed accumulator width per lane.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous to clk, active-high.
REQ-006 rec_di_coeff  input  NW x N_NEURONS  per-lane coefficient, signed two's complement.
REQ-007 rec_di_neuron  input  NW x N_NEURONS  per-lane neuron operand.
REQ-008 rec_di_neuron_sign  input  1  1: neuron operands are signed (LR source); 0: unsigned (IP source).
REQ-009 rec_us_hold  input  1  freeze every register in the block.
REQ-010 rec_us_mac  input  1  accumulate coeff x neuron this cycle.
REQ-011 rec_us_acc_clr  input  1  clear all accumulators.
REQ-012 rec_us_act  input  1  request activation of current accumulators.
REQ-013 rec_us_relu  input  1  apply ReLU during the requested activation.
REQ-014 rec_us_shift  input  4  arithmetic right shift applied before activation saturation.
REQ-015 rec_act_result  output  NW x N_NEURONS  activation result per lane, signed.
REQ-016 rec_act_valid  output  1  activation result updated.
REQ-017 rec_mac_ovf  output  1  sticky: some accumulator saturated since last clear.

Function
REQ-018 All input sampling and register updates SHALL be suppressed while rec_us_hold=1; every register, outputs included, SHALL retain its value.
REQ-019 Stage 1 (S1) SHALL register per lane prod = coeff(signed 9b sign-extended) x neuron (sign-extended to 9b if neuron_sign=1, zero-extended otherwise), 18-bit signed, plus flags mac, clr, act, relu, shift.
REQ-020 Stage 2 (S2) SHALL update each accumulator: clr&mac -> prod; clr&~mac -> 0; ~clr&mac -> acc+prod; else hold.
REQ-021 acc+prod SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any lane saturating SHALL set rec_mac_ovf.
REQ-022 rec_mac_ovf SHALL clear when an S1 clr is applied in S2, except that saturation in the same cycle (clr&mac cannot saturate) leaves it cleared.
REQ-023 An act flag in S2 SHALL be forwarded to stage 3 (S3) together with the post-update accumulator value of that same cycle.
REQ-024 S3 SHALL compute per lane: v = acc >>> shift; if relu and v<0 then v=0; saturate v to [-128,127]; register into rec_act_result.
REQ-025 rec_act_valid SHALL be a registered single-cycle pulse coincident with the rec_act_result update; rec_act_result SHALL hold between activations.
REQ-026 Latency: inputs sampled at edge t affect accumulators at edge t+2; act sampled at t yields rec_act_valid=1 after edge t+3, including any mac sampled at t.
REQ-027 Back-to-back act requests SHALL each produce one pulse, one per cycle, fully pipelined.
REQ-028 If hold asserts while rec_act_valid=1, rec_act_valid SHALL remain 1 until the first unheld edge, then deassert.
REQ-029 rec_us_act with no intervening mac SHALL re-output the activation of unchanged accumulators.

Reset
REQ-030 On rst=1 at an edge: all accumulators 0, all S1/S3 flags 0, rec_act_result all 0, rec_act_valid 0, rec_mac_ovf 0; rst SHALL take priority over hold.
REQ-031 In-flight mac/act operations at reset SHALL be discarded with no rec_act_valid pulse.

Verification
REQ-032 clr+mac coeff=3, neuron=5 (sign=0) all lanes, then act shift=0 -> rec_act_valid at t+3, every lane =15.
REQ-033 mac coeff=-2, neuron=0xFF: sign=1 -> product +2; sign=0 -> product -510; act shift=1 relu=0 -> 1 and -128 (saturated).
REQ-034 4 macs coeff=127 neuron=255 then act shift=15 -> acc=129540, result 3; 20 further macs -> acc saturates at 524287, rec_mac_ovf=1; clr -> ovf=0.
REQ-035 act relu=1 on negative acc -> 0; act relu=0 with acc=-4096 shift=4 -> -128.
REQ-036 mac+act issued, hold asserted 3 cycles at t+1 -> rec_act_valid appears at t+6, value includes the mac.
REQ-037 rst asserted one cycle after act issue -> no rec_act_valid, all outputs 0, a subsequent act outputs 0.
